// File: rtl/pipe_reg_skid_if.sv
// Ready/valid handshake bundle for the two-entry skid buffer.
// The slave view belongs to the buffer; the master view belongs to whoever drives it.
interface pipe_reg_skid_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             flush;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_reg_skid.sv
// Two-entry skid buffer: a head register feeding out_data plus one skid register.
// Every handshake output is a flop, so there is no combinational path across the stage.
module pipe_reg_skid #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic             clk,
    input logic             rst_n,
    pipe_reg_skid_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] head_p0;
    logic [WIDTH-1:0] skid_p0;
    logic             vld_p0;
    logic             rdy_p0;
    logic [1:0]       cnt_p0;

    logic accept;
    logic issue;

    assign accept = bus.in_valid & rdy_p0;
    assign issue  = vld_p0 & bus.out_ready;

    // Stage p0: state, data registers and handshake outputs all update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            head_p0 <= RESET_VAL;
            skid_p0 <= RESET_VAL;
            vld_p0  <= 1'b0;
            rdy_p0  <= 1'b1;
            cnt_p0  <= 2'd0;
        end else if (bus.flush) begin
            // Flush wins over any accept or issue in the same cycle.
            state   <= EMPTY;
            head_p0 <= RESET_VAL;
            skid_p0 <= RESET_VAL;
            vld_p0  <= 1'b0;
            rdy_p0  <= 1'b1;
            cnt_p0  <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_p0 <= bus.in_data;
                        state   <= ONE;
                        vld_p0  <= 1'b1;
                        rdy_p0  <= 1'b1;
                        cnt_p0  <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        head_p0 <= bus.in_data;
                    end else if (accept) begin
                        skid_p0 <= bus.in_data;
                        state   <= FULL;
                        vld_p0  <= 1'b1;
                        rdy_p0  <= 1'b0;
                        cnt_p0  <= 2'd2;
                    end else if (issue) begin
                        state   <= EMPTY;
                        vld_p0  <= 1'b0;
                        rdy_p0  <= 1'b1;
                        cnt_p0  <= 2'd0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the downstream side can move.
                    if (issue) begin
                        head_p0 <= skid_p0;
                        state   <= ONE;
                        vld_p0  <= 1'b1;
                        rdy_p0  <= 1'b1;
                        cnt_p0  <= 2'd1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    vld_p0  <= 1'b0;
                    rdy_p0  <= 1'b1;
                    cnt_p0  <= 2'd0;
                end
            endcase
        end
    end

    assign bus.out_data  = head_p0;
    assign bus.out_valid = vld_p0;
    assign bus.in_ready  = rdy_p0;
    assign bus.count     = cnt_p0;
endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed scenarios plus a FIFO scoreboard on the 16-bit instance,
// and a second 32-bit instance with a non-zero reset value.
module tb_pipe_reg_skid;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_word;

    always #5 clk = ~clk;

    pipe_reg_skid_if #(.WIDTH(16)) b16 ();
    pipe_reg_skid_if #(.WIDTH(32)) b32 ();

    pipe_reg_skid #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
    );

    pipe_reg_skid #(.WIDTH(32), .RESET_VAL(32'hDEADBEEF)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(b32)
    );

    // Scoreboard: inputs only change after negedge, so values read here are the pre-edge ones.
    always @(posedge clk) begin
        if (!rst_n || b16.flush) begin
            sb.delete();
        end else begin
            if (b16.out_valid && b16.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow got=%h required=nothing", b16.out_data);
                end else begin
                    exp_word = sb.pop_front();
                    if (b16.out_data !== exp_word) begin
                        failures++;
                        $display("FAIL sb_order got=%h required=%h", b16.out_data, exp_word);
                    end
                end
            end
            if (b16.in_valid && b16.in_ready) sb.push_back(b16.in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b0; b16.flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.out_ready = 1'b0; b32.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b required=0", b16.out_valid); end
        checks++; if (b16.count !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d required=0", b16.count); end
        checks++; if (b16.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b required=1", b16.in_ready); end
        checks++; if (b16.out_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data got=%h required=0000", b16.out_data); end
        checks++; if (b32.out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_out_data32 got=%h required=deadbeef", b32.out_data); end
        rst_n = 1'b1;
        tick();
        checks++; if (b16.out_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_valid got=%b required=0", b16.out_valid); end
    endtask

    task automatic test_stream();
        b16.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            b16.in_valid = 1'b1;
            b16.in_data  = 16'(i);
            tick();
            checks++;
            if (b16.out_data !== 16'(i) || b16.out_valid !== 1'b1 || b16.count !== 2'd1) begin
                failures++;
                $display("FAIL stream_%0d got data=%h valid=%b count=%0d required data=%h valid=1 count=1",
                         i, b16.out_data, b16.out_valid, b16.count, 16'(i));
            end
        end
        b16.in_valid = 1'b0;
        tick();
        checks++; if (b16.out_valid !== 1'b0 || b16.count !== 2'd0) begin failures++; $display("FAIL stream_drain got valid=%b count=%0d required valid=0 count=0", b16.out_valid, b16.count); end
    endtask

    task automatic test_backpressure();
        b16.out_ready = 1'b0;
        b16.in_valid = 1'b1; b16.in_data = 16'hAAAA; tick();
        b16.in_data = 16'hBBBB; tick();
        checks++; if (b16.count !== 2'd2) begin failures++; $display("FAIL bp_count got=%0d required=2", b16.count); end
        checks++; if (b16.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b required=0", b16.in_ready); end
        checks++; if (b16.out_data !== 16'hAAAA) begin failures++; $display("FAIL bp_hold got=%h required=aaaa", b16.out_data); end
        b16.in_data = 16'hCCCC; tick();
        checks++; if (b16.count !== 2'd2 || b16.out_data !== 16'hAAAA) begin failures++; $display("FAIL bp_ignore got data=%h count=%0d required data=aaaa count=2", b16.out_data, b16.count); end
        b16.in_valid = 1'b0; b16.out_ready = 1'b1; tick();
        checks++; if (b16.out_data !== 16'hBBBB || b16.count !== 2'd1) begin failures++; $display("FAIL bp_second got data=%h count=%0d required data=bbbb count=1", b16.out_data, b16.count); end
        tick();
        checks++; if (b16.out_valid !== 1'b0 || b16.count !== 2'd0 || b16.in_ready !== 1'b1) begin failures++; $display("FAIL bp_empty got valid=%b count=%0d ready=%b required 0/0/1", b16.out_valid, b16.count, b16.in_ready); end
        b16.out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        b16.out_ready = 1'b0;
        b16.in_valid = 1'b1; b16.in_data = 16'h1234; tick();
        checks++; if (b16.out_data !== 16'h1234 || b16.count !== 2'd1) begin failures++; $display("FAIL sim_load got data=%h count=%0d required data=1234 count=1", b16.out_data, b16.count); end
        b16.in_data = 16'h5678; b16.out_ready = 1'b1; tick();
        checks++; if (b16.out_data !== 16'h5678 || b16.count !== 2'd1) begin failures++; $display("FAIL sim_swap got data=%h count=%0d required data=5678 count=1", b16.out_data, b16.count); end
        b16.in_valid = 1'b0; tick();
        checks++; if (b16.count !== 2'd0) begin failures++; $display("FAIL sim_drain got count=%0d required=0", b16.count); end
        b16.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        b16.out_ready = 1'b0;
        b16.in_valid = 1'b1; b16.in_data = 16'h1111; tick();
        b16.in_data = 16'h2222; tick();
        checks++; if (b16.count !== 2'd2) begin failures++; $display("FAIL flush_fill got count=%0d required=2", b16.count); end
        b16.flush = 1'b1; b16.in_data = 16'h9999; b16.out_ready = 1'b1; tick();
        b16.flush = 1'b0; b16.in_valid = 1'b0;
        checks++; if (b16.count !== 2'd0 || b16.out_valid !== 1'b0) begin failures++; $display("FAIL flush_state got count=%0d valid=%b required count=0 valid=0", b16.count, b16.out_valid); end
        checks++; if (b16.out_data !== 16'h0000) begin failures++; $display("FAIL flush_data got=%h required=0000", b16.out_data); end
        tick();
        checks++; if (b16.out_valid !== 1'b0 || b16.out_data === 16'h9999) begin failures++; $display("FAIL flush_leak got data=%h valid=%b required valid=0", b16.out_data, b16.out_valid); end
        b16.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        b16.out_ready = 1'b0;
        b16.in_valid = 1'b1; b16.in_data = 16'h4444; tick();
        b16.in_data = 16'h5555; tick();
        b16.in_valid = 1'b0;
        checks++; if (b16.count !== 2'd2) begin failures++; $display("FAIL arst_fill got count=%0d required=2", b16.count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (b16.out_valid !== 1'b0 || b16.count !== 2'd0 || b16.in_ready !== 1'b1 || b16.out_data !== 16'h0000) begin
            failures++;
            $display("FAIL arst_immediate got valid=%b count=%0d ready=%b data=%h required 0/0/1/0000",
                     b16.out_valid, b16.count, b16.in_ready, b16.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (b16.out_valid !== 1'b0 || b16.count !== 2'd0) begin failures++; $display("FAIL arst_after got valid=%b count=%0d required 0/0", b16.out_valid, b16.count); end
    endtask

    task automatic test_param();
        b32.out_ready = 1'b1;
        b32.in_valid = 1'b1; b32.in_data = 32'hFFFFFFFF; tick();
        checks++; if (b32.out_data !== 32'hFFFFFFFF || b32.out_valid !== 1'b1) begin failures++; $display("FAIL p32_ones got data=%h valid=%b required ffffffff/1", b32.out_data, b32.out_valid); end
        b32.in_data = 32'h00000000; tick();
        checks++; if (b32.out_data !== 32'h00000000 || b32.count !== 2'd1) begin failures++; $display("FAIL p32_zeros got data=%h count=%0d required 00000000/1", b32.out_data, b32.count); end
        b32.in_valid = 1'b0; tick();
        checks++; if (b32.out_valid !== 1'b0 || b32.count !== 2'd0) begin failures++; $display("FAIL p32_drain got valid=%b count=%0d required 0/0", b32.out_valid, b32.count); end
        b32.flush = 1'b1; tick(); b32.flush = 1'b0;
        checks++; if (b32.out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL p32_flush got=%h required=deadbeef", b32.out_data); end
        b32.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_param();
        tick();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter WIDTH, default 16, data path width in bits (legal range 1..64).
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}, value loaded into all data registers on reset and flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk by the system.
REQ-005 in_valid  input  1  upstream presents in_data.
REQ-006 in_data  input  WIDTH  upstream data word.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_data  output  WIDTH  head-of-buffer word.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 flush  input  1  synchronous discard of all buffered words.
REQ-012 count  output  2  number of buffered words (0..2).

Function
REQ-013 Block SHALL be a 2-entry skid buffer: head register (drives out_data) plus skid register.
REQ-014 State machine SHALL have exactly three states: EMPTY (count=0), ONE (count=1), FULL (count=2).
REQ-015 accept = in_valid & in_ready; issue = out_valid & out_ready; both evaluated in the same cycle.
REQ-016 in_ready SHALL be high in EMPTY and ONE, low in FULL, and SHALL be a function of registered state only (no combinational path from out_ready or in_valid).
REQ-017 out_valid SHALL be high in ONE and FULL, low in EMPTY, driven from registered state only.
REQ-018 EMPTY: accept -> head<=in_data, ONE; no accept -> stay EMPTY.
REQ-019 ONE: accept & issue -> head<=in_data, stay ONE; accept only -> skid<=in_data, FULL; issue only -> EMPTY; neither -> stay ONE.
REQ-020 FULL: issue -> head<=skid, ONE; no issue -> stay FULL, head and skid unchanged.
REQ-021 Latency SHALL be one cycle: word accepted at edge N is on out_data with out_valid high after edge N.
REQ-022 Ordering SHALL be strict FIFO; no word duplicated or dropped except by flush or reset.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Registers not loaded in a cycle SHALL hold their value; no write on in_valid while in_ready=0.
REQ-025 flush=1 at an edge SHALL force EMPTY, head and skid to RESET_VAL, with priority over any simultaneous accept or issue (accepted word discarded).
REQ-026 count SHALL equal 0/1/2 for EMPTY/ONE/FULL, registered.
REQ-027 Throughput SHALL be one word per cycle sustained when out_ready is continuously high.

Reset
REQ-028 rst_n=0 SHALL immediately, without clk, force EMPTY, head=skid=RESET_VAL, out_valid=0, count=0, in_ready=1.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; first edge after deassertion behaves as EMPTY.
REQ-030 Outputs SHALL be defined (no X) from reset assertion onward.

Verification
REQ-031 Reset: rst_n low asynchronously between edges with count=2 -> out_valid=0, count=0, in_ready=1, out_data=0x0000 before next edge.
REQ-032 Stream: out_ready=1, in_valid=1 with 0x0001..0x0010 on consecutive cycles -> out_data 0x0001..0x0010 one cycle later each, count=1 throughout, no gaps.
REQ-033 Backpressure: out_ready=0, push 0xAAAA then 0xBBBB -> count=2, in_ready=0, out_data=0xAAAA held; in_valid with 0xCCCC while full ignored; out_ready=1 -> 0xAAAA, 0xBBBB, then EMPTY.
REQ-034 Simultaneous in ONE: head=0x1234, accept 0x5678 and issue same edge -> out_data=0x5678, count=1.
REQ-035 Flush priority: count=2, flush=1 with in_valid=1 (0x9999) and out_ready=1 -> count=0, out_valid=0, 0x9999 never appears at output.
REQ-036 Parameter: WIDTH=32, RESET_VAL=0xDEADBEEF -> after reset out_data=0xDEADBEEF; stream 0xFFFFFFFF, 0x00000000 passes intact.
